// File: rtl/main_memory_block_ctrl.sv
// Block-oriented main-memory model: one block request at a time, a fixed
// access latency, then BLOCK_WORDS beats streamed out (read) or in (write).
module main_memory_block_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wdata_valid,
   output logic              wdata_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              rdata_last,
   output logic              busy,
   output logic              done
);

   localparam int BW = $clog2(BLOCK_WORDS);
   localparam int DW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [BW-1:0] LAST_BEAT  = BW'(BLOCK_WORDS - 1);
   localparam logic [DW-1:0] ALIGN_MASK = ~DW'(BLOCK_WORDS - 1);
   localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RBURST,
      S_WBURST
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_nxt;
   logic [BW-1:0]     r_beat;
   logic [BW-1:0]     w_beat_nxt;
   logic [DW-1:0]     r_base;
   logic              r_write;
   logic              r_done;
   logic              w_done_nxt;
   logic              w_accept;
   logic              w_wr_en;
   logic              w_last;
   logic [DW-1:0]     w_idx;
   logic [DATA_W-1:0] w_rd_word;
   logic              w_unused;

   logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

   // Power-on image of word i, also used to scramble stored values.
   function automatic logic [DATA_W-1:0] f_pattern(input logic [DW-1:0] idx);
      return DATA_W'(32'hA000_0000) | DATA_W'(idx);
   endfunction

   assign w_unused  = ^req_addr;
   assign w_idx     = r_base | DW'(r_beat);
   assign w_last    = (r_beat == LAST_BEAT);
   assign w_rd_word = r_mem[w_idx] ^ f_pattern(w_idx);
   assign done      = r_done & ~RST;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_beat_nxt  = r_beat;
      w_done_nxt  = 1'b0;
      w_accept    = 1'b0;
      w_wr_en     = 1'b0;
      req_ready   = 1'b0;
      wdata_ready = 1'b0;
      rdata_valid = 1'b0;
      rdata_last  = 1'b0;
      rdata       = '0;
      busy        = 1'b0;
      if (!RST) begin
         unique case (r_state)
            S_IDLE: begin
               req_ready = 1'b1;
               if (req_valid) begin
                  w_accept    = 1'b1;
                  w_cnt_nxt   = CNT_INIT;
                  w_state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               busy = 1'b1;
               if (r_cnt == '0) begin
                  w_beat_nxt  = '0;
                  w_state_nxt = r_write ? S_WBURST : S_RBURST;
               end else begin
                  w_cnt_nxt = r_cnt - CW'(1);
               end
            end
            S_RBURST: begin
               busy        = 1'b1;
               rdata_valid = 1'b1;
               rdata       = w_rd_word;
               rdata_last  = w_last;
               w_beat_nxt  = r_beat + BW'(1);
               if (w_last) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_WBURST: begin
               busy        = 1'b1;
               wdata_ready = 1'b1;
               if (wdata_valid) begin
                  w_wr_en    = 1'b1;
                  w_beat_nxt = r_beat + BW'(1);
                  if (w_last) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_beat  <= '0;
         r_base  <= '0;
         r_write <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_beat  <= w_beat_nxt;
         r_done  <= w_done_nxt;
         if (w_accept) begin
            r_base  <= req_addr[DW-1:0] & ALIGN_MASK;
            r_write <= req_write;
         end
      end
   end

   // Stored as XOR against the power-on image so all-zero storage reads back
   // as that image; reset never touches the array.
   always_ff @(posedge CLK) begin
      if (w_wr_en) r_mem[w_idx] <= wdata ^ f_pattern(w_idx);
   end

endmodule
